// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - show-ahead FIFO holding ALU results with their opcode tag and flags
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [2:0]               in_sel,
  input  logic [3:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [2:0]               out_sel,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     sticky_clr,
  output logic [3:0]               sticky_flags,
  output logic [7:0]               push_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [2:0]       sel_mem  [DEPTH];
  logic [3:0]       flag_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    sticky_q, sticky_d;
  logic [7:0]    push_cnt_q, push_cnt_d;
  logic          push, pop;

  // Handshake depends only on registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sticky_d   = sticky_q;
    push_cnt_d = push_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // A clear coinciding with a push leaves exactly that push's flags.
    if (sticky_clr) sticky_d = push ? in_flags : 4'b0000;
    else if (push)  sticky_d = sticky_q | in_flags;
    if (push && push_cnt_q != 8'hFF) push_cnt_d = push_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sticky_q   <= 4'b0000;
      push_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sticky_q   <= sticky_d;
      push_cnt_q <= push_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= in_data;
      sel_mem[wr_ptr_q]  <= in_sel;
      flag_mem[wr_ptr_q] <= in_flags;
    end
  end

  assign out_data     = data_mem[rd_ptr_q];
  assign out_sel      = sel_mem[rd_ptr_q];
  assign out_flags    = flag_mem[rd_ptr_q];
  assign count        = count_q;
  assign sticky_flags = sticky_q;
  assign push_cnt     = push_cnt_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - self-checking bench for alu_result_buffer
module tb_alu_result_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic [3:0] in_flags;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [2:0] out_sel;
  logic [3:0] out_flags;
  logic [2:0] count;
  logic       sticky_clr;
  logic [3:0] sticky_flags;
  logic [7:0] push_cnt;

  int checks = 0;
  int failures = 0;

  logic [14:0] mq[$];
  logic [3:0]  msticky;
  int          mpc;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [2:0] s;
    logic [3:0] f;
    logic       r;
    logic       c;
    int         e_cnt;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_d;
    logic [3:0] e_st;
    int         e_pc;
  } vec_t;

  vec_t vecs[13];

  alu_result_buffer #(.DEPTH(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_flags(out_flags),
    .count(count), .sticky_clr(sticky_clr), .sticky_flags(sticky_flags),
    .push_cnt(push_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a queue of {data,sel,flags}; accept iff fewer than 4 held, release iff non-empty.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] s,
                       input logic [3:0] f, input logic r, input logic c);
    logic push, pop;
    in_valid = v; in_data = d; in_sel = s; in_flags = f; out_ready = r; sticky_clr = c;
    push = v && (mq.size() < 4);
    pop  = r && (mq.size() != 0);
    @(posedge clk);
    if (c) msticky = 4'b0000;
    if (push) begin
      msticky = msticky | f;
      mpc = (mpc >= 255) ? 255 : mpc + 1;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({d, s, f});
    @(negedge clk);
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".count"}, int'(count), mq.size());
    chk({tag, ".in_ready"}, int'(in_ready), int'(mq.size() < 4));
    chk({tag, ".out_valid"}, int'(out_valid), int'(mq.size() != 0));
    chk({tag, ".sticky"}, int'(sticky_flags), int'(msticky));
    chk({tag, ".push_cnt"}, int'(push_cnt), mpc);
    if (mq.size() != 0) begin
      chk({tag, ".out_data"}, int'(out_data), int'(mq[0][14:7]));
      chk({tag, ".out_sel"}, int'(out_sel), int'(mq[0][6:4]));
      chk({tag, ".out_flags"}, int'(out_flags), int'(mq[0][3:0]));
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'd15, 3'd0, 4'b0000, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'd15, 4'b0000, 1};
    vecs[1]  = '{1'b1, 8'd5,  3'd1, 4'b0001, 1'b0, 1'b0, 2, 1'b1, 1'b1, 8'd15, 4'b0001, 2};
    vecs[2]  = '{1'b1, 8'd15, 3'd2, 4'b0100, 1'b0, 1'b0, 3, 1'b1, 1'b1, 8'd15, 4'b0101, 3};
    vecs[3]  = '{1'b1, 8'd0,  3'd3, 4'b0000, 1'b0, 1'b0, 4, 1'b0, 1'b1, 8'd15, 4'b0101, 4};
    vecs[4]  = '{1'b1, 8'd50, 3'd4, 4'b1000, 1'b0, 1'b0, 4, 1'b0, 1'b1, 8'd15, 4'b0101, 4};
    vecs[5]  = '{1'b1, 8'd50, 3'd4, 4'b1000, 1'b1, 1'b0, 3, 1'b1, 1'b1, 8'd5,  4'b0101, 4};
    vecs[6]  = '{1'b1, 8'd50, 3'd4, 4'b1000, 1'b0, 1'b1, 4, 1'b0, 1'b1, 8'd5,  4'b1000, 5};
    vecs[7]  = '{1'b0, 8'd0,  3'd0, 4'b0000, 1'b1, 1'b0, 3, 1'b1, 1'b1, 8'd15, 4'b1000, 5};
    vecs[8]  = '{1'b1, 8'd7,  3'd5, 4'b0010, 1'b1, 1'b0, 3, 1'b1, 1'b1, 8'd0,  4'b1010, 6};
    vecs[9]  = '{1'b0, 8'd0,  3'd0, 4'b0000, 1'b1, 1'b0, 2, 1'b1, 1'b1, 8'd50, 4'b1010, 6};
    vecs[10] = '{1'b1, 8'd9,  3'd6, 4'b0000, 1'b1, 1'b0, 2, 1'b1, 1'b1, 8'd7,  4'b1010, 7};
    vecs[11] = '{1'b0, 8'd0,  3'd0, 4'b0000, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'd9,  4'b1010, 7};
    vecs[12] = '{1'b0, 8'd0,  3'd0, 4'b0000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'd0,  4'b1010, 7};

    rst_n = 1'b0; in_valid = 0; in_data = 0; in_sel = 0; in_flags = 0;
    out_ready = 0; sticky_clr = 0;
    mq.delete(); msticky = 4'b0000; mpc = 0;
    repeat (3) @(negedge clk);
    chk("reset.count", int'(count), 0);
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.in_ready", int'(in_ready), 1);
    chk("reset.sticky", int'(sticky_flags), 0);
    chk("reset.push_cnt", int'(push_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].f, vecs[i].r, vecs[i].c);
      chk($sformatf("vec%0d.count", i), int'(count), vecs[i].e_cnt);
      chk($sformatf("vec%0d.in_ready", i), int'(in_ready), int'(vecs[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk($sformatf("vec%0d.out_data", i), int'(out_data), int'(vecs[i].e_d));
      chk($sformatf("vec%0d.sticky", i), int'(sticky_flags), int'(vecs[i].e_st));
      chk($sformatf("vec%0d.push_cnt", i), int'(push_cnt), vecs[i].e_pc);
    end

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom), 4'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      model_check($sformatf("rand%0d", i));
    end

    for (int i = 0; i < 8 && mq.size() != 0; i++) cycle(0, 0, 0, 0, 1, 0);
    chk("drain.empty", int'(count), 0);
    cycle(1, 8'd11, 3'd1, 4'b0001, 0, 0);
    cycle(1, 8'd22, 3'd2, 4'b0010, 0, 0);
    cycle(1, 8'd33, 3'd3, 4'b0100, 0, 0);
    model_check("pre_reset");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst.count", int'(count), 0);
    chk("midrst.out_valid", int'(out_valid), 0);
    chk("midrst.in_ready", int'(in_ready), 1);
    chk("midrst.sticky", int'(sticky_flags), 0);
    chk("midrst.push_cnt", int'(push_cnt), 0);
    mq.delete(); msticky = 4'b0000; mpc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 8'hA5, 3'd7, 4'b1001, 0, 0);
    model_check("post_reset");
    chk("post_reset.head", int'(out_data), 8'hA5);

    for (int i = 0; i < 300; i++) begin
      cycle(1, 8'($urandom), 3'($urandom), 4'($urandom), 1, 0);
      model_check($sformatf("sat%0d", i));
    end
    chk("sat.push_cnt", int'(push_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries (power of two, >=2).
REQ-002 SHALL have parameter WIDTH, default 8, result data width, matching the 8-bit ALU output.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream ALU result valid.
REQ-006 SHALL have port in_ready, output, 1, buffer can accept a result this cycle.
REQ-007 SHALL have port in_data, input, WIDTH, ALU result (out).
REQ-008 SHALL have port in_sel, input, 3, opcode tag that produced the result.
REQ-009 SHALL have port in_flags, input, 4, {carry, zeroFlag, negFlag, OverFlowFlag} from ALU.
REQ-010 SHALL have port out_valid, output, 1, head entry available.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts head entry.
REQ-012 SHALL have port out_data, output, WIDTH, head result.
REQ-013 SHALL have port out_sel, output, 3, head opcode tag.
REQ-014 SHALL have port out_flags, output, 4, head flags, same bit order as in_flags.
REQ-015 SHALL have port count, output, clog2(DEPTH)+1, current occupancy.
REQ-016 SHALL have port sticky_clr, input, 1, synchronous clear of sticky_flags.
REQ-017 SHALL have port sticky_flags, output, 4, OR of flags of all accepted results since last clear/reset.
REQ-018 SHALL have port push_cnt, output, 8, saturating count of accepted results.

Function
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL equal (count < DEPTH), derived from registered count only; no combinational path from out_ready.
REQ-021 out_valid SHALL equal (count != 0).
REQ-022 out_data/out_sel/out_flags SHALL present storage at read pointer (show-ahead); values undefined-but-stable when out_valid=0.
REQ-023 Latency SHALL be 1 cycle: result pushed into empty buffer at edge N is visible with out_valid=1 after edge N.
REQ-024 No bypass: a push into an empty buffer SHALL NOT appear on out_* in the same cycle.
REQ-025 Entries SHALL leave in strict push order (FIFO).
REQ-026 Write and read pointers SHALL wrap modulo DEPTH.
REQ-027 Push-only: count +1; pop-only: count -1; push and pop same cycle: count unchanged, both pointers advance.
REQ-028 When full, in_ready=0; a pop in that cycle SHALL NOT enable a same-cycle push.
REQ-029 Held input (in_valid=1, in_ready=0) SHALL be accepted on first cycle in_ready=1, unchanged.
REQ-030 On push, sticky_flags SHALL become sticky_flags | in_flags.
REQ-031 sticky_clr SHALL zero sticky_flags; with simultaneous push, result SHALL equal in_flags of that push.
REQ-032 push_cnt SHALL increment per push and saturate at 255.
REQ-033 Pop from empty and push to full SHALL be impossible by handshake; state SHALL not change for such attempts.

Reset
REQ-034 rst_n=0 SHALL asynchronously force count=0, pointers=0, out_valid=0, in_ready=1, sticky_flags=0, push_cnt=0.
REQ-035 Storage contents SHALL NOT require reset; out_data/out_sel/out_flags need not be reset.
REQ-036 Reset mid-operation SHALL discard all stored entries; first push after rst_n release behaves as into empty buffer.

Verification
REQ-037 Push in_data=15, in_sel=000, in_flags=0000 into empty, out_ready=0 -> next cycle out_valid=1, out_data=15, count=1, push_cnt=1.
REQ-038 out_ready=0, push 4 results (5,15,0,50) -> count=4, in_ready=0; fifth held input accepted only after one pop; drain order 5,15,0,50.
REQ-039 count=2, push and pop same cycle -> count stays 2, popped entry is oldest, new entry last.
REQ-040 Push flags 0001 then 0100 -> sticky_flags=0101; sticky_clr with push flags 1000 -> sticky_flags=1000.
REQ-041 count=3, pulse rst_n low mid-cycle -> count=0, out_valid=0, sticky_flags=0, push_cnt=0 immediately, before next clk edge.
REQ-042 256+ pushes with continuous pop -> push_cnt holds 255, no wrap.
